// File: rtl/pong_game_ctrl_if.sv
// pong_game_ctrl_if: point/tick/button inputs and score/overlay outputs of the Pong sequencer.
interface pong_game_ctrl_if;
   logic       frame_tick;
   logic       btn_start;
   logic       point_l;
   logic       point_r;
   logic [3:0] dig0;
   logic [3:0] dig1;
   logic [3:0] dig2;
   logic [3:0] dig3;
   logic [1:0] ball;
   logic       graph_still;
   logic       show_score;
   logic       show_over;
   logic [1:0] state_o;
   modport master (
      output frame_tick, btn_start, point_l, point_r,
      input  dig0, dig1, dig2, dig3, ball, graph_still, show_score, show_over, state_o
   );
   modport slave (
      input  frame_tick, btn_start, point_l, point_r,
      output dig0, dig1, dig2, dig3, ball, graph_still, show_score, show_over, state_o
   );
endinterface

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: Pong game sequencer with BCD scores, serve/game-over timers and overlay enables.
module pong_game_ctrl #(
   parameter int WIN_SCORE   = 11,
   parameter int SERVE_TICKS = 120,
   parameter int OVER_TICKS  = 180,
   parameter int TW          = 8
) (
   input logic            clk,
   input logic            reset_n,
   pong_game_ctrl_if.slave bus
);
   localparam logic [3:0] WIN_T = 4'(WIN_SCORE / 10);
   localparam logic [3:0] WIN_O = 4'(WIN_SCORE % 10);
   typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, OVER = 2'd3} state_t;
   state_t        state, state_n;
   logic          btn_q, start_edge;
   logic [TW-1:0] timer, timer_n;
   logic [7:0]    score_l, score_r, score_l_n, score_r_n, inc_l, inc_r;
   logic [1:0]    ball, ball_n;
   logic          graph_still, show_score, show_over;
   logic          win_l, win_r, load_serve, load_over, clear;

   // tens saturate at 9 so 99 + 1 holds at 99
   function automatic logic [7:0] bcd_inc(input logic [7:0] s);
      return s[3:0] == 4'd9 ? (s[7:4] == 4'd9 ? s : {s[7:4] + 4'd1, 4'd0})
                            : {s[7:4], s[3:0] + 4'd1};
   endfunction

   assign start_edge = bus.btn_start & ~btn_q;
   assign inc_l      = bcd_inc(score_l);
   assign inc_r      = bcd_inc(score_r);
   assign win_l      = inc_l == {WIN_T, WIN_O};
   assign win_r      = inc_r == {WIN_T, WIN_O};

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else          state <= state_n;

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = start_edge ? SERVE : IDLE;
         SERVE:   state_n = timer == '0 ? PLAY : SERVE;
         PLAY:    state_n = bus.point_l ? (win_l ? OVER : SERVE)
                          : bus.point_r ? (win_r ? OVER : SERVE) : PLAY;
         OVER:    state_n = (start_edge && timer == '0) ? SERVE : OVER;
         default: state_n = IDLE;
      endcase
   end

   // a load on entering SERVE/OVER overrides a coincident frame tick
   always_comb begin
      load_serve = state_n == SERVE && state != SERVE;
      load_over  = state_n == OVER && state != OVER;
      clear      = state == OVER && state_n == SERVE;
      timer_n    = load_serve ? TW'(SERVE_TICKS)
                 : load_over ? TW'(OVER_TICKS)
                 : (bus.frame_tick && timer != '0) ? timer - 1'b1 : timer;
      score_l_n  = clear ? 8'd0 : (state == PLAY && bus.point_l) ? inc_l : score_l;
      score_r_n  = clear ? 8'd0 : (state == PLAY && !bus.point_l && bus.point_r) ? inc_r : score_r;
      ball_n     = load_over ? 2'd0
                 : load_serve ? ((state == PLAY && bus.point_l) ? 2'd2 : 2'd1) : ball;
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         btn_q       <= 1'b0;
         timer       <= '0;
         score_l     <= 8'd0;
         score_r     <= 8'd0;
         ball        <= 2'd0;
         graph_still <= 1'b1;
         show_score  <= 1'b1;
         show_over   <= 1'b0;
      end else begin
         btn_q       <= bus.btn_start;
         timer       <= timer_n;
         score_l     <= score_l_n;
         score_r     <= score_r_n;
         ball        <= ball_n;
         graph_still <= state_n != PLAY;
         show_score  <= 1'b1;
         show_over   <= state_n == OVER;
      end

   assign bus.dig0        = score_l[3:0];
   assign bus.dig1        = score_l[7:4];
   assign bus.dig2        = score_r[3:0];
   assign bus.dig3        = score_r[7:4];
   assign bus.ball        = ball;
   assign bus.graph_still = graph_still;
   assign bus.show_score  = show_score;
   assign bus.show_over   = show_over;
   assign bus.state_o     = state;
endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Game-sequencing controller for the two-player Pong display.
- Keeps both players' scores as BCD digit pairs and drives the score and "GAME OVER" text overlay.
- Freezes or releases the ball graphics and times the serve delay and game-over hold using frame ticks.
- Sits between the ball/paddle graphics logic, which produces point events, and the text overlay, which consumes the digits and region enables.

Parameters:
- WIN_SCORE, 11: score that ends the game. Legal range 1..99. Elaborated into constants WIN_T = WIN_SCORE/10 and WIN_O = WIN_SCORE%10.
- SERVE_TICKS, 120: frame ticks of ball freeze before each serve (2 s at 60 Hz).
- OVER_TICKS, 180: frame ticks the game-over screen ignores the start button.
- TW, 8: timer width; SERVE_TICKS and OVER_TICKS must each be < 2^TW.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-clk pulse per video frame
- btn_start  in  1  debounced start button, level
- point_l  in  1  one-clk pulse: left player scored
- point_r  in  1  one-clk pulse: right player scored
- dig0  out  4  left score ones (BCD)
- dig1  out  4  left score tens (BCD)
- dig2  out  4  right score ones (BCD)
- dig3  out  4  right score tens (BCD)
- ball  out  2  server indicator: 0 none, 1 left, 2 right
- graph_still  out  1  1 = ball frozen at serve position
- show_score  out  1  enable score text region
- show_over  out  1  enable game-over text region
- state_o  out  2  current FSM state (debug)

Behaviour:
- Clocking and reset
  - Single clock domain; all outputs registered.
  - reset_n low asynchronously forces: state IDLE, all digits 0, ball=0, graph_still=1, show_score=1, show_over=0, timer=0, btn_q=0.
  - Reset mid-game or mid-timer discards everything; there is no resume.
- Start button edge
  - btn_q <= btn_start each clk; start_edge = btn_start & ~btn_q.
  - A held button produces exactly one edge.
- States (state_o encoding): IDLE=0, SERVE=1, PLAY=2, OVER=3.
- IDLE
  - graph_still=1, show_over=0, ball=0.
  - start_edge -> SERVE; timer <= SERVE_TICKS; ball <= 1 (left serves first).
- SERVE
  - graph_still=1.
  - Each frame_tick with timer>0 decrements timer.
  - The cycle the state is in SERVE with timer==0 -> PLAY (timer 0 means one-cycle SERVE).
  - point_l and point_r are ignored.
- PLAY
  - graph_still=0.
  - point_l: left score += 1 (BCD).
    - If the new score equals {WIN_T,WIN_O} -> OVER, timer <= OVER_TICKS, ball <= 0.
    - Otherwise -> SERVE, timer <= SERVE_TICKS, ball <= 2 (loser serves).
  - point_r: symmetric on dig3/dig2, ball <= 1.
  - point_l and point_r in the same cycle: left takes priority; point_r is dropped.
  - Digits and state update on the same edge, one clk after the pulse.
- BCD increment
  - ones==9 -> ones=0, tens+1; otherwise ones+1.
  - tens saturates at 9; 99 + 1 stays 99 (unreachable for legal WIN_SCORE).
- OVER
  - graph_still=1, show_over=1, show_score=1.
  - timer decrements on frame_tick.
  - start_edge is ignored while timer>0.
  - start_edge with timer==0: clear all digits -> SERVE, timer <= SERVE_TICKS, ball <= 1, show_over <= 0.
  - point pulses are ignored.
- Timer
  - Decrements only on frame_tick; never wraps below 0.
  - frame_tick coinciding with a state transition: the load value wins.
- show_score is 1 in every state.

Test Plan:
- Reset then idle: assert reset_n=0 mid-PLAY with score 05-03 -> same cycle, digits 0, state_o=0, graph_still=1, ball=0; no transition without btn_start.
- Serve timing: SERVE_TICKS=3, press btn_start -> state 1 for exactly 3 frame_ticks, then state 2 and graph_still=0 on the next clk; holding btn for 100 clks gives one start only.
- BCD carry: 10 point_l pulses in PLAY (re-serving between each) -> dig1=1, dig0=0; after each point ball=2 and state=SERVE.
- Win: WIN_SCORE=11, left at 10, point_l -> dig1=1, dig0=1, state=OVER, show_over=1, ball=0; right digits unchanged.
- Simultaneous points: point_l and point_r in the same clk at 02-02 -> 03-02, ball=2.
- Game-over hold: OVER_TICKS=4, btn press after 2 ticks ignored; press after 4 ticks -> digits 00-00, state=SERVE, show_over=0, ball=1.
